// File: rtl/mem_responder_if.sv
// mem_responder_if: datapath-to-memory request/response bundle.
interface mem_responder_if;
   logic        memread;
   logic        memwrite;
   logic        ifetch;
   logic [15:0] addr;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [15:0] instruction;
   logic        ready;
   logic        addrerr;
   logic        busy;
   modport master (output memread, memwrite, ifetch, addr, writedata,
                   input readdata, instruction, ready, addrerr, busy);
   modport slave (input memread, memwrite, ifetch, addr, writedata,
                  output readdata, instruction, ready, addrerr, busy);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-organised unified memory answering after LATENCY wait states.
module mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input logic             clk,
   input logic             reset,
   mem_responder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   state_t        state;
   logic [3:0]    cnt;
   logic [15:0]   a_q;
   logic [15:0]   wd_q;
   logic          wr_q;
   logic          rd_q;
   logic          if_q;
   logic [AW-1:0] idx;
   logic          err;
   logic          fire;
   logic [15:0]   rdval;
   logic [15:0]   mem [DEPTH];
   assign idx   = a_q[AW:1];
   assign err   = a_q[0] | ({1'b0, a_q[15:1]} >= 16'(DEPTH));
   assign fire  = (state == S_WAIT) && (cnt == 4'd0);
   // write-first: a combined read/write returns the data being written
   assign rdval = wr_q ? wd_q : mem[idx];
   always_ff @(posedge clk)
      if (fire && wr_q && !err) mem[idx] <= wd_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state           <= S_IDLE;
         cnt             <= 4'd0;
         a_q             <= 16'd0;
         wd_q            <= 16'd0;
         wr_q            <= 1'b0;
         rd_q            <= 1'b0;
         if_q            <= 1'b0;
         bus.readdata    <= 16'd0;
         bus.instruction <= 16'd0;
         bus.ready       <= 1'b0;
         bus.addrerr     <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         bus.ready   <= 1'b0;
         bus.addrerr <= 1'b0;
         case (state)
            S_IDLE:
               if (bus.memread || bus.memwrite) begin
                  a_q      <= bus.addr;
                  wd_q     <= bus.writedata;
                  wr_q     <= bus.memwrite;
                  rd_q     <= bus.memread;
                  if_q     <= bus.ifetch;
                  cnt      <= 4'(LATENCY - 1);
                  state    <= S_WAIT;
                  bus.busy <= 1'b1;
               end
            S_WAIT:
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
               else begin
                  state       <= S_DONE;
                  bus.ready   <= 1'b1;
                  bus.addrerr <= err;
                  if (rd_q && !err && if_q) bus.instruction <= rdval;
                  if (rd_q && !err && !if_q) bus.readdata <= rdval;
               end
            S_DONE: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, read/write/fetch, errors and reset abort.
module tb_mem_responder;
   logic clk = 1'b0;
   logic ra;
   logic rb;
   int   errors = 0;
   int   checks = 0;
   int   n;
   int   k;
   logic [15:0] exp_bb [3];
   mem_responder_if ifa ();
   mem_responder_if ifb ();
   mem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (.clk(clk), .reset(ra), .bus(ifa));
   mem_responder #(.DEPTH(256), .LATENCY(3)) dut_b (.clk(clk), .reset(rb), .bus(ifb));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask
   task automatic drive(input bit b, input logic rd, input logic wr, input logic ifc,
                        input logic [15:0] a, input logic [15:0] d);
      if (b) begin
         ifb.memread = rd; ifb.memwrite = wr; ifb.ifetch = ifc; ifb.addr = a; ifb.writedata = d;
      end else begin
         ifa.memread = rd; ifa.memwrite = wr; ifa.ifetch = ifc; ifa.addr = a; ifa.writedata = d;
      end
   endtask
   // issue one request and leave the bench at the negedge where ready is seen
   task automatic xact(input bit b, input logic rd, input logic wr, input logic ifc,
                       input logic [15:0] a, input logic [15:0] d, input string tag);
      int c;
      @(negedge clk);
      drive(b, rd, wr, ifc, a, d);
      @(negedge clk);
      drive(b, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      c = 0;
      while (!(b ? ifb.ready : ifa.ready) && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk({tag, " latency"}, 16'(c), b ? 16'd3 : 16'd2);
   endtask
   initial begin
      ra = 1'b1;
      rb = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(negedge clk);
      chkb("rst ready", ifa.ready, 1'b0);
      chkb("rst busy", ifa.busy, 1'b0);
      chkb("rst addrerr", ifa.addrerr, 1'b0);
      chk("rst readdata", ifa.readdata, 16'h0000);
      chk("rst instruction", ifa.instruction, 16'h0000);
      ra = 1'b0;
      rb = 1'b0;
      xact(0, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h1234, "wr4");
      chkb("wr4 addrerr", ifa.addrerr, 1'b0);
      xact(0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, "rd4");
      chk("rd4 readdata", ifa.readdata, 16'h1234);
      chk("rd4 instruction held", ifa.instruction, 16'h0000);
      chkb("rd4 busy in done", ifa.busy, 1'b1);
      @(negedge clk);
      chkb("rd4 ready one cycle", ifa.ready, 1'b0);
      chkb("rd4 busy idle", ifa.busy, 1'b0);
      xact(0, 1'b0, 1'b1, 1'b0, 16'h0006, 16'hA5C3, "wr6");
      xact(0, 1'b1, 1'b0, 1'b1, 16'h0006, 16'h0000, "fetch6");
      chk("fetch6 instruction", ifa.instruction, 16'hA5C3);
      chk("fetch6 readdata held", ifa.readdata, 16'h1234);
      xact(0, 1'b1, 1'b1, 1'b0, 16'h0008, 16'h7777, "rw8");
      chk("rw8 readdata", ifa.readdata, 16'h7777);
      chk("rw8 instruction held", ifa.instruction, 16'hA5C3);
      @(negedge clk);
      chkb("rw8 ready one cycle", ifa.ready, 1'b0);
      xact(0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, "rd4b");
      chk("rd4b readdata", ifa.readdata, 16'h1234);
      xact(0, 1'b1, 1'b0, 1'b0, 16'h0008, 16'h0000, "rd8");
      chk("rd8 mem4", ifa.readdata, 16'h7777);
      xact(0, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h5555, "wr2");
      xact(0, 1'b0, 1'b1, 1'b0, 16'h0003, 16'hDEAD, "wr3 odd");
      chkb("wr3 addrerr", ifa.addrerr, 1'b1);
      chkb("wr3 ready", ifa.ready, 1'b1);
      xact(0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000, "rd2");
      chk("rd2 mem1 unchanged", ifa.readdata, 16'h5555);
      chkb("rd2 addrerr", ifa.addrerr, 1'b0);
      xact(0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, "rd200");
      chkb("rd200 addrerr", ifa.addrerr, 1'b1);
      chk("rd200 readdata held", ifa.readdata, 16'h5555);
      @(negedge clk);
      chkb("rd200 addrerr one cycle", ifa.addrerr, 1'b0);
      xact(0, 1'b0, 1'b1, 1'b0, 16'h01FE, 16'h0BAD, "wr1fe");
      chkb("wr1fe addrerr", ifa.addrerr, 1'b0);
      xact(0, 1'b1, 1'b0, 1'b1, 16'h01FE, 16'h0000, "fetch1fe");
      chk("fetch1fe instruction", ifa.instruction, 16'h0BAD);
      xact(0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00AA, "wr0");
      exp_bb[0] = 16'h00AA;
      exp_bb[1] = 16'h5555;
      exp_bb[2] = 16'h1234;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      k = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (ifa.ready) begin
            chk("b2b cycle", 16'(i), 16'(3 + 4 * k));
            chk("b2b readdata", ifa.readdata, k < 3 ? exp_bb[k] : 16'hXXXX);
            k++;
            ifa.addr = 16'(2 * k);
         end
      end
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("b2b ready count", 16'(k), 16'd3);
      @(negedge clk);
      chkb("b2b idle", ifa.busy, 1'b0);
      drive(0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);
      @(negedge clk);
      n = 0;
      while (!ifa.ready && n < 20) begin
         ifa.memread = ~ifa.memread;
         ifa.memwrite = ~ifa.memwrite;
         ifa.addr = 16'h0000;
         ifa.writedata = 16'hFFFF;
         @(negedge clk);
         n++;
      end
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("toggle latency", 16'(n), 16'd2);
      chk("toggle readdata", ifa.readdata, 16'h1234);
      k = 0;
      repeat (6) begin
         @(negedge clk);
         if (ifa.ready) k++;
      end
      chk("toggle extra ready", 16'(k), 16'd1 - 16'd1);
      xact(0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, "rd0");
      chk("rd0 not overwritten", ifa.readdata, 16'h00AA);
      xact(1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h1111, "b wr10");
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chkb("b busy in wait", ifb.busy, 1'b1);
      @(negedge clk);
      rb = 1'b1;
      #1;
      chkb("b rst busy", ifb.busy, 1'b0);
      chkb("b rst ready", ifb.ready, 1'b0);
      @(negedge clk);
      chkb("b rst busy held", ifb.busy, 1'b0);
      chkb("b rst ready held", ifb.ready, 1'b0);
      rb = 1'b0;
      xact(1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, "b rd10");
      chk("b rd10 aborted write", ifb.readdata, 16'h1111);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-organised unified instruction/data memory that answers the multicycle datapath's memory interface.
- The datapath drives addr, writedata and the read/write strobes; this block returns readdata or instruction after a programmable wait-state latency.
- A one-cycle ready pulse accompanies each response, so the control FSM can stall until it sees ready.
- Addresses are byte addresses on 16-bit words (PC increments by 2).

Parameters:
- DEPTH, 256: number of 16-bit words; must be a power of two, no larger than 32768.
- LATENCY, 2: wait states between request acceptance and response; legal range 1 to 15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- memread  input  1  read request strobe
- memwrite  input  1  write request strobe
- ifetch  input  1  qualifies a read as an instruction fetch
- addr  input  16  byte address; addr[0] must be 0
- writedata  input  16  write data
- readdata  output  16  registered data-read result
- instruction  output  16  registered instruction-fetch result
- ready  output  1  one-cycle response/completion pulse
- addrerr  output  1  one-cycle error pulse, coincident with ready
- busy  output  1  high in WAIT and DONE

Behaviour:
- Reset (async, active-high): state goes to IDLE; readdata, instruction, ready, addrerr and busy all go to 0; the wait counter clears; any pending access is discarded, including a pending write, which is never performed. Memory array contents are not reset.
- Word index = addr[log2(DEPTH):1].
- FSM states:
  - IDLE: on a clk edge with memread or memwrite high, latch addr, writedata, memwrite, memread and ifetch; load cnt = LATENCY-1; go to WAIT. Otherwise stay in IDLE.
  - WAIT: if cnt > 0, decrement cnt. If cnt == 0, perform the access and go to DONE. Strobe changes during WAIT are ignored.
  - DONE: ready = 1 for exactly this cycle; go to IDLE on the next edge. Requests during DONE are ignored.
- Timing: request accepted at edge t gives ready high during the cycle after edge t+LATENCY. The earliest next acceptance is edge t+LATENCY+2.
- Access performed at the WAIT to DONE edge:
  - Latched write: mem[index] <= latched writedata.
  - Latched read with ifetch=1: instruction <= mem[index].
  - Latched read with ifetch=0: readdata <= mem[index].
  - memread and memwrite both high: the write is performed, and the selected read output takes the newly written value (write-first).
  - Outputs not targeted by the access hold their previous value; readdata and instruction hold until overwritten.
- Error handling: if the latched addr[0]=1, or addr[15:1] >= DEPTH, then no write occurs, no read output changes, and addrerr=1 alongside ready in DONE. The handshake still completes normally.
- ready and addrerr are high only in DONE; busy = (state != IDLE).
- Combinational read paths from addr to the outputs are not permitted; all outputs are registered.

Test Plan:
- Reset mid-WAIT: LATENCY=3, issue memwrite addr=0x0010 data=0xBEEF, assert reset at the second WAIT cycle. Then read 0x0010 -> ready pulses with the prior value, not 0xBEEF; busy=0 and ready=0 during reset.
- Latency and write-then-read: LATENCY=2, memwrite at edge t (addr=0x0004, data=0x1234), then memread at edge t+4 (ifetch=0) -> ready high after edges t+2 and t+6 only; readdata=0x1234 after t+6; instruction unchanged.
- Instruction fetch isolation: preload mem[3]=0xA5C3, memread+ifetch addr=0x0006 -> instruction=0xA5C3 with ready; readdata retains its old value.
- Simultaneous read/write: memread+memwrite addr=0x0008 data=0x7777 -> ready once; readdata=0x7777; mem[4]=0x7777.
- Errors: write addr=0x0003 -> addrerr=ready=1, mem[1] unchanged. Read addr=0x0200 with DEPTH=256 -> addrerr=1, readdata unchanged.
- Back-to-back and ignored strobes: hold memread high continuously with addr stepping 0,2,4 -> one ready every LATENCY+2 cycles; toggling strobes during WAIT/DONE produces no extra ready.
